// File: rtl/g15_tape_punch.sv
// Device-side G-15 paper-tape punch: runs the punch mechanism sync, captures codes
// from the I/O section at the end of each sync pulse, echoes them and queues them for a host.
module g15_tape_punch #(
    parameter int SYNC_PERIOD = 64,
    parameter int SYNC_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int IDLE_SYNCS  = 4
) (
    input  logic        CLOCK,
    input  logic        rst,
    input  logic        OB1,
    input  logic        OB2,
    input  logic        OB3,
    input  logic        OB4,
    input  logic        OB5,
    input  logic        PUNCH_SIGNAL,
    output logic        PUNCH_SYNC,
    output logic        PUNCHED_TAPE1,
    output logic        PUNCHED_TAPE2,
    output logic        PUNCHED_TAPE3,
    output logic        PUNCHED_TAPE4,
    output logic        PUNCHED_TAPE5,
    output logic        MOTOR,
    output logic        HOST_VALID,
    output logic [4:0]  HOST_DATA,
    input  logic        HOST_READY,
    output logic        OVERRUN,
    output logic [15:0] PUNCH_COUNT
);

    localparam int CW = $clog2(SYNC_PERIOD);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(IDLE_SYNCS + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(SYNC_PERIOD - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(SYNC_PERIOD - SYNC_WIDTH - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_SYNCS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idle_cnt;

    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    logic [4:0]    code;
    logic          empty;
    logic          full;
    logic          sample;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          stall_req;

    assign code      = {OB5, OB4, OB3, OB2, OB1};
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign sample    = (state == RUN) && (cnt == CNT_LAST);
    assign push_req  = sample && PUNCH_SIGNAL;
    assign push      = push_req && !full;
    assign pop       = !empty && HOST_READY;
    // Stall only on the cycle just before the sync window so a pulse is never cut short.
    assign stall_req = (state == RUN) && (cnt == CNT_PRE) && full;

    assign HOST_VALID = !empty;
    assign HOST_DATA  = empty ? 5'd0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idle_cnt    <= '0;
            PUNCH_SYNC  <= 1'b0;
            MOTOR       <= 1'b0;
            OVERRUN     <= 1'b0;
            PUNCH_COUNT <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            {PUNCHED_TAPE5, PUNCHED_TAPE4, PUNCHED_TAPE3, PUNCHED_TAPE2, PUNCHED_TAPE1} <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt        <= '0;
                    PUNCH_SYNC <= 1'b0;
                    if (PUNCH_SIGNAL) begin
                        state <= RUN;
                        MOTOR <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        PUNCH_SYNC <= 1'b0;
                        if (PUNCH_SIGNAL) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_MAX) begin
                            idle_cnt <= '0;
                            state    <= IDLE;
                            MOTOR    <= 1'b0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else if (stall_req) begin
                        state      <= STALL;
                        PUNCH_SYNC <= 1'b0;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        PUNCH_SYNC <= (cnt >= CNT_PRE);
                    end
                end
                STALL: begin
                    if (!full) begin
                        state      <= RUN;
                        cnt        <= cnt + 1'b1;
                        PUNCH_SYNC <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    PUNCH_SYNC <= 1'b0;
                    MOTOR      <= 1'b0;
                end
            endcase

            if (push_req) begin
                {PUNCHED_TAPE5, PUNCHED_TAPE4, PUNCHED_TAPE3, PUNCHED_TAPE2, PUNCHED_TAPE1} <= code;
                PUNCH_COUNT <= PUNCH_COUNT + 16'd1;
            end
            if (push_req && full) begin
                OVERRUN <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers define which
    // entries are valid, and HOST_DATA is forced to zero while empty.
    always_ff @(posedge CLOCK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= code;
        end
    end

endmodule

// File: tb/tb_g15_tape_punch.sv
// Directed bench for g15_tape_punch with SYNC_PERIOD=8, SYNC_WIDTH=2, FIFO_DEPTH=4, IDLE_SYNCS=3.
// Inputs change and outputs are checked on the falling clock edge.
module tb_g15_tape_punch;

    logic        CLOCK;
    logic        rst;
    logic        OB1, OB2, OB3, OB4, OB5;
    logic        PUNCH_SIGNAL;
    logic        PUNCH_SYNC;
    logic        PUNCHED_TAPE1, PUNCHED_TAPE2, PUNCHED_TAPE3, PUNCHED_TAPE4, PUNCHED_TAPE5;
    logic        MOTOR;
    logic        HOST_VALID;
    logic [4:0]  HOST_DATA;
    logic        HOST_READY;
    logic        OVERRUN;
    logic [15:0] PUNCH_COUNT;

    int tests_run = 0;
    int tests_failed = 0;

    g15_tape_punch #(
        .SYNC_PERIOD(8),
        .SYNC_WIDTH (2),
        .FIFO_DEPTH (4),
        .IDLE_SYNCS (3)
    ) dut (
        .CLOCK        (CLOCK),
        .rst          (rst),
        .OB1          (OB1),
        .OB2          (OB2),
        .OB3          (OB3),
        .OB4          (OB4),
        .OB5          (OB5),
        .PUNCH_SIGNAL (PUNCH_SIGNAL),
        .PUNCH_SYNC   (PUNCH_SYNC),
        .PUNCHED_TAPE1(PUNCHED_TAPE1),
        .PUNCHED_TAPE2(PUNCHED_TAPE2),
        .PUNCHED_TAPE3(PUNCHED_TAPE3),
        .PUNCHED_TAPE4(PUNCHED_TAPE4),
        .PUNCHED_TAPE5(PUNCHED_TAPE5),
        .MOTOR        (MOTOR),
        .HOST_VALID   (HOST_VALID),
        .HOST_DATA    (HOST_DATA),
        .HOST_READY   (HOST_READY),
        .OVERRUN      (OVERRUN),
        .PUNCH_COUNT  (PUNCH_COUNT)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic set_code(input logic [4:0] c);
        {OB5, OB4, OB3, OB2, OB1} = c;
    endtask

    function automatic logic [4:0] tape();
        return {PUNCHED_TAPE5, PUNCHED_TAPE4, PUNCHED_TAPE3, PUNCHED_TAPE2, PUNCHED_TAPE1};
    endfunction

    initial begin
        rst          = 1'b1;
        PUNCH_SIGNAL = 1'b0;
        HOST_READY   = 1'b0;
        set_code(5'd0);
        step(2);

        check("rst_sync",    32'(PUNCH_SYNC),  32'd0);
        check("rst_motor",   32'(MOTOR),       32'd0);
        check("rst_valid",   32'(HOST_VALID),  32'd0);
        check("rst_data",    32'(HOST_DATA),   32'd0);
        check("rst_tape",    32'(tape()),      32'd0);
        check("rst_overrun", 32'(OVERRUN),     32'd0);
        check("rst_count",   32'(PUNCH_COUNT), 32'd0);
        rst = 1'b0;

        // Single punch of 0x16; motor starts on the first edge.
        PUNCH_SIGNAL = 1'b1;
        HOST_READY   = 1'b1;
        set_code(5'b10110);
        step(1);
        check("start_motor", 32'(MOTOR),      32'd1);
        check("start_sync",  32'(PUNCH_SYNC), 32'd0);
        step(5);
        check("c6_sync_low", 32'(PUNCH_SYNC), 32'd0);
        step(1);
        check("c7_sync_hi",  32'(PUNCH_SYNC), 32'd1);
        step(1);
        check("c8_sync_hi",  32'(PUNCH_SYNC), 32'd1);
        check("c8_valid",    32'(HOST_VALID), 32'd0);
        step(1);
        check("c9_sync_low", 32'(PUNCH_SYNC),  32'd0);
        check("c9_valid",    32'(HOST_VALID),  32'd1);
        check("c9_data",     32'(HOST_DATA),   32'h16);
        check("c9_tape",     32'(tape()),      32'h16);
        check("c9_count",    32'(PUNCH_COUNT), 32'd1);
        PUNCH_SIGNAL = 1'b0;
        step(1);
        check("c10_popped",  32'(HOST_VALID),  32'd0);
        check("c10_tape",    32'(tape()),      32'h16);

        // Idle shutdown after three empty sample points (edges 17, 25, 33).
        step(22);
        check("idle_motor_on",  32'(MOTOR),      32'd1);
        step(1);
        check("idle_motor_off", 32'(MOTOR),      32'd0);
        check("idle_sync_off",  32'(PUNCH_SYNC), 32'd0);

        // Restart and burst 0x01..0x06 with the host stalled.
        PUNCH_SIGNAL = 1'b1;
        HOST_READY   = 1'b0;
        set_code(5'h01);
        step(1);
        check("restart_motor", 32'(MOTOR), 32'd1);
        step(5);
        check("restart_c6_sync", 32'(PUNCH_SYNC), 32'd0);
        step(1);
        check("restart_c7_sync", 32'(PUNCH_SYNC), 32'd1);
        step(2);
        check("burst1_valid", 32'(HOST_VALID), 32'd1);
        check("burst1_data",  32'(HOST_DATA),  32'h01);
        set_code(5'h02);
        step(8);
        set_code(5'h03);
        step(8);
        set_code(5'h04);
        step(8);
        check("burst4_count", 32'(PUNCH_COUNT), 32'd5);
        check("burst4_tape",  32'(tape()),      32'h04);
        set_code(5'h05);
        step(6);
        check("stall_sync_low", 32'(PUNCH_SYNC), 32'd0);
        check("stall_motor",    32'(MOTOR),      32'd1);
        step(6);
        check("stall_held_sync", 32'(PUNCH_SYNC),  32'd0);
        check("stall_head",      32'(HOST_DATA),   32'h01);
        check("stall_count",     32'(PUNCH_COUNT), 32'd5);

        // Drain: one pop per cycle, stall releases once the FIFO has room.
        HOST_READY = 1'b1;
        step(1);
        check("drain_2",       32'(HOST_DATA),  32'h02);
        check("drain_2_sync",  32'(PUNCH_SYNC), 32'd0);
        step(1);
        check("drain_3",       32'(HOST_DATA),  32'h03);
        check("drain_3_sync",  32'(PUNCH_SYNC), 32'd1);
        step(1);
        check("drain_4",       32'(HOST_DATA),  32'h04);
        step(1);
        check("drain_5_valid", 32'(HOST_VALID), 32'd1);
        check("drain_5",       32'(HOST_DATA),  32'h05);
        set_code(5'h06);
        step(1);
        check("drain_empty",   32'(HOST_VALID), 32'd0);
        step(7);
        check("drain_6",       32'(HOST_DATA),   32'h06);
        check("burst_count",   32'(PUNCH_COUNT), 32'd7);
        check("burst_overrun", 32'(OVERRUN),     32'd0);

        // Push and pop on the same edge with two entries queued.
        HOST_READY = 1'b0;
        set_code(5'h07);
        step(8);
        set_code(5'h08);
        step(7);
        HOST_READY = 1'b1;
        step(1);
        check("pp_head",  32'(HOST_DATA),  32'h07);
        check("pp_valid", 32'(HOST_VALID), 32'd1);
        PUNCH_SIGNAL = 1'b0;
        step(1);
        check("pp_second", 32'(HOST_DATA),  32'h08);
        step(1);
        check("pp_empty",  32'(HOST_VALID), 32'd0);

        // Reset during a sync pulse with three entries queued.
        HOST_READY   = 1'b0;
        PUNCH_SIGNAL = 1'b1;
        set_code(5'h11);
        step(6);
        set_code(5'h12);
        step(8);
        set_code(5'h13);
        step(8);
        step(6);
        check("pre_rst_sync", 32'(PUNCH_SYNC), 32'd1);
        check("pre_rst_head", 32'(HOST_DATA),  32'h11);
        rst = 1'b1;
        step(1);
        check("mid_rst_sync",    32'(PUNCH_SYNC),  32'd0);
        check("mid_rst_motor",   32'(MOTOR),       32'd0);
        check("mid_rst_valid",   32'(HOST_VALID),  32'd0);
        check("mid_rst_data",    32'(HOST_DATA),   32'd0);
        check("mid_rst_tape",    32'(tape()),      32'd0);
        check("mid_rst_count",   32'(PUNCH_COUNT), 32'd0);
        rst          = 1'b0;
        PUNCH_SIGNAL = 1'b0;
        step(2);
        check("post_rst_motor", 32'(MOTOR),      32'd0);
        check("post_rst_valid", 32'(HOST_VALID), 32'd0);

        // Defensive path: stall disabled, fifth push lands on a full FIFO.
        force dut.stall_req = 1'b0;
        PUNCH_SIGNAL = 1'b1;
        set_code(5'h0A);
        step(9);
        set_code(5'h0B);
        step(8);
        set_code(5'h0C);
        step(8);
        set_code(5'h0D);
        step(8);
        check("ovr_count4",   32'(PUNCH_COUNT), 32'd4);
        check("ovr_pre_flag", 32'(OVERRUN),     32'd0);
        set_code(5'h0E);
        step(6);
        check("ovr_no_stall", 32'(PUNCH_SYNC), 32'd1);
        step(2);
        check("ovr_flag",     32'(OVERRUN),    32'd1);
        check("ovr_head",     32'(HOST_DATA),  32'h0A);
        PUNCH_SIGNAL = 1'b0;
        release dut.stall_req;
        HOST_READY = 1'b1;
        step(1);
        check("ovr_drain_b", 32'(HOST_DATA), 32'h0B);
        step(1);
        check("ovr_drain_c", 32'(HOST_DATA), 32'h0C);
        step(1);
        check("ovr_drain_d", 32'(HOST_DATA), 32'h0D);
        step(1);
        check("ovr_drain_empty", 32'(HOST_VALID), 32'd0);
        check("ovr_sticky",      32'(OVERRUN),    32'd1);
        rst = 1'b1;
        step(1);
        check("ovr_cleared", 32'(OVERRUN), 32'd0);
        rst = 1'b0;
        step(1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
